// File: rtl/n0prime_if.sv
// Handshake and result bundle for n0prime_param: start/n in, n0prime/done/busy/err/chk_fail out.
// Protocol: start is sampled only while the unit is idle; n0prime/err (and chk_fail) are valid while done is high.
interface n0prime_if #(
  parameter int N_WIDTH = 4096,
  parameter int W       = 64
);
  logic               start;
  logic [N_WIDTH-1:0] n;
  logic [W-1:0]       n0prime;
  logic               done;
  logic               busy;
  logic               err;
  logic               chk_fail;
  logic [1:0]         dbg_state;

  modport master (
    output start, n,
    input  n0prime, done, busy, err, chk_fail, dbg_state
  );

  modport slave (
    input  start, n,
    output n0prime, done, busy, err, chk_fail, dbg_state
  );
endinterface

// File: rtl/n0prime_param.sv
// Bit-serial Montgomery constant n0prime = -n^-1 mod 2^W, one result bit per cycle.
// Optional post-check of n0_r*x == -1 mod 2^W enabled by N0PRIME_SELFCHECK_EN.
module n0prime_param #(
  parameter int N_WIDTH = 4096,
  parameter int W       = 64
) (
  input  logic     clk,
  input  logic     reset,
  n0prime_if.slave bus
);
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2, CHK = 2'd3} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  n0_r_q, n0_r_d;
  logic [W:0]    t_q, t_d;
  logic [W-1:0]  x_q, x_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  n0prime_q, n0prime_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic [W:0]    sum;
  logic          unused_n;

  // Only the low word of n matters; the reduction just consumes the rest.
  assign unused_n = ^bus.n[N_WIDTH-1:0];

`ifdef N0PRIME_SELFCHECK_EN
  logic         chk_fail_q, chk_fail_d;
  logic [W-1:0] p;
  assign p = n0_r_q * x_q;
  assign bus.chk_fail = chk_fail_q;
`else
  assign bus.chk_fail = 1'b0;
`endif

  assign sum = t_q + {1'b0, n0_r_q};

  always_comb begin
    state_d   = state_q;
    n0_r_d    = n0_r_q;
    t_d       = t_q;
    x_d       = x_q;
    cnt_d     = cnt_q;
    n0prime_d = n0prime_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    err_d     = err_q;
`ifdef N0PRIME_SELFCHECK_EN
    chk_fail_d = chk_fail_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          n0_r_d = bus.n[W-1:0];
          err_d  = 1'b0;
          busy_d = 1'b1;
          x_d    = '0;
`ifdef N0PRIME_SELFCHECK_EN
          chk_fail_d = 1'b0;
`endif
          if (!bus.n[0]) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else begin
            t_d     = {{W{1'b0}}, 1'b1};
            cnt_d   = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // x bit cnt is t[0]; adding n0_r then clears t[0] so the shift is exact.
        if (t_q[0]) begin
          x_d = x_q | (W'(1) << cnt_q);
          t_d = {1'b0, sum[W:1]};
        end else begin
          t_d = {1'b0, t_q[W:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
`ifdef N0PRIME_SELFCHECK_EN
          state_d = CHK;
`else
          state_d = FIN;
`endif
        end
      end
`ifdef N0PRIME_SELFCHECK_EN
      CHK: begin
        chk_fail_d = (p != '1);
        state_d    = FIN;
      end
`endif
      FIN: begin
        // First FIN edge raises done; the second retires back to IDLE.
        if (!done_q) begin
          n0prime_d = x_q;
          done_d    = 1'b1;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      n0_r_q    <= '0;
      t_q       <= '0;
      x_q       <= '0;
      cnt_q     <= '0;
      n0prime_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef N0PRIME_SELFCHECK_EN
      chk_fail_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      n0_r_q    <= n0_r_d;
      t_q       <= t_d;
      x_q       <= x_d;
      cnt_q     <= cnt_d;
      n0prime_q <= n0prime_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
`ifdef N0PRIME_SELFCHECK_EN
      chk_fail_q <= chk_fail_d;
`endif
    end
  end

  assign bus.n0prime   = n0prime_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;
  assign bus.dbg_state = state_q;
endmodule
